// File: rtl/e_mdu_multicycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes, FSM states, op decode.
package e_mdu_multicycle_pkg;

  typedef enum logic [4:0] {
    MDU_NONE  = 5'd0,
    MDU_MULT  = 5'd1,
    MDU_MULTU = 5'd2,
    MDU_DIV   = 5'd3,
    MDU_DIVU  = 5'd4,
    MDU_MADD  = 5'd5,
    MDU_MADDU = 5'd6,
    MDU_MSUB  = 5'd7,
    MDU_MSUBU = 5'd8,
    MDU_MFHI  = 5'd9,
    MDU_MFLO  = 5'd10,
    MDU_MTHI  = 5'd11,
    MDU_MTLO  = 5'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  // Accumulating ops only count as multiplies when the accumulator is built in.
  function automatic logic is_mul_op(mdu_op_e op, logic acc_en);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (acc_en && (op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU}));
  endfunction

  function automatic logic is_div_op(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_multicycle_if.sv
// Request/response bundle between the pipeline (master) and the MDU (slave).
interface e_mdu_multicycle_if #(
  parameter int unsigned DATA_W = 32
);
  import e_mdu_multicycle_pkg::*;

  logic [DATA_W-1:0] i_srcA;
  logic [DATA_W-1:0] i_srcB;
  mdu_op_e           i_mduOp;
  logic              i_start;
  logic              i_flush;
  logic [DATA_W-1:0] or_hi;
  logic [DATA_W-1:0] or_lo;
  logic [DATA_W-1:0] or_result;
  logic              or_busy;
  logic              o_done;

  modport master (
    output i_srcA, i_srcB, i_mduOp, i_start, i_flush,
    input  or_hi, or_lo, or_result, or_busy, o_done
  );

  modport slave (
    input  i_srcA, i_srcB, i_mduOp, i_start, i_flush,
    output or_hi, or_lo, or_result, or_busy, o_done
  );

endinterface

// File: rtl/mdu_divide.sv
// Combinational signed/unsigned divide with MIPS-style zero-divisor and MIN/-1 fix-ups.
module mdu_divide #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              sgn,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else if (sgn && (dividend == MinVal) && (divisor == '1)) begin
      // Overflowing quotient wraps to MIN instead of trapping.
      quotient  = MinVal;
      remainder = '0;
    end else if (sgn) begin
      quotient  = $unsigned($signed(dividend) / $signed(divisor));
      remainder = $unsigned($signed(dividend) % $signed(divisor));
    end else begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// File: rtl/e_mdu_multicycle.sv
// Multi-cycle multiply/divide unit holding HI/LO; fixed-latency ops tracked by a down-counter.
module e_mdu_multicycle
  import e_mdu_multicycle_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter bit          ACC_EN   = 1'b1
) (
  input logic               i_clk,
  input logic               i_reset_n,
  e_mdu_multicycle_if.slave mdu
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);
  localparam int unsigned W2     = 2 * DATA_W;

  mdu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  mdu_op_e           op_q, op_d;
  logic              done_q, done_d;

  logic              mul_signed;
  logic [W2-1:0]     ext_a, ext_b, prod, mul_res;
  logic [DATA_W-1:0] quot, rem;

  // Full-width product from sign/zero-extended operands; low 2*DATA_W bits are exact.
  assign mul_signed = op_q inside {MDU_MULT, MDU_MADD, MDU_MSUB};
  assign ext_a = mul_signed ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
  assign ext_b = mul_signed ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

  // HI/LO cannot change while busy, so they still hold their value from acceptance.
  always_comb begin
    mul_res = prod;
    case (op_q)
      MDU_MADD, MDU_MADDU: mul_res = {hi_q, lo_q} + prod;
      MDU_MSUB, MDU_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:             mul_res = prod;
    endcase
  end

  mdu_divide #(
    .DATA_W(DATA_W)
  ) u_divide (
    .dividend  (a_q),
    .divisor   (b_q),
    .sgn       (op_q == MDU_DIV),
    .quotient  (quot),
    .remainder (rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu.i_start && !mdu.i_flush) begin
          if (is_mul_op(mdu.i_mduOp, ACC_EN)) begin
            state_d = MUL;
            cnt_d   = CntW'(MULT_LAT);
            a_d     = mdu.i_srcA;
            b_d     = mdu.i_srcB;
            op_d    = mdu.i_mduOp;
          end else if (is_div_op(mdu.i_mduOp)) begin
            state_d = DIV;
            cnt_d   = CntW'(DIV_LAT);
            a_d     = mdu.i_srcA;
            b_d     = mdu.i_srcB;
            op_d    = mdu.i_mduOp;
          end else if (mdu.i_mduOp == MDU_MTHI) begin
            hi_d = mdu.i_srcA;
          end else if (mdu.i_mduOp == MDU_MTLO) begin
            lo_d = mdu.i_srcA;
          end
        end
      end
      MUL, DIV: begin
        if (mdu.i_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (state_q == MUL) begin
              {hi_d, lo_d} = mul_res;
            end else begin
              hi_d = rem;
              lo_d = quot;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MDU_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign mdu.or_hi   = hi_q;
  assign mdu.or_lo   = lo_q;
  assign mdu.or_busy = (state_q != IDLE);
  assign mdu.o_done  = done_q;

  always_comb begin
    case (mdu.i_mduOp)
      MDU_MFHI: mdu.or_result = hi_q;
      MDU_MFLO: mdu.or_result = lo_q;
      default:  mdu.or_result = '0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu_multicycle.sv
// Directed bench for e_mdu_multicycle: vector table plus flush/reset/accumulate sequences.
module tb_e_mdu_multicycle;
  import e_mdu_multicycle_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int          ML  = 5;
  localparam int          DL  = 10;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  e_mdu_multicycle_if #(.DATA_W(DW)) bus ();

  e_mdu_multicycle #(
    .DATA_W   (DW),
    .MULT_LAT (ML),
    .DIV_LAT  (DL),
    .ACC_EN   (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .mdu       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents a request for one edge; returns at posedge+1 with the request withdrawn.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.i_mduOp = op;
    bus.i_srcA  = a;
    bus.i_srcB  = b;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_mduOp = MDU_NONE;
  endtask

  task automatic wait_done(input int exp_busy, input logic [31:0] ehi, input logic [31:0] elo,
                           input string name);
    int nb = 0;
    bit got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bus.o_done) got = 1'b1;
      else if (bus.or_busy) nb++;
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " busy_cycles"}, 32'(nb), 32'(exp_busy));
    chk({name, " busy_at_done"}, 32'(bus.or_busy), 32'd0);
    chk({name, " hi"}, bus.or_hi, ehi);
    chk({name, " lo"}, bus.or_lo, elo);
    @(posedge clk);
    #1;
    chk({name, " done_width"}, 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    bit done_seen;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, ML, "mult_neg1x2"};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, ML, "multu_max_x2"};
    vecs[2] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, ML, "mult_min_sq"};
    vecs[3] = '{MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, DL, "divu_100_7"};
    vecs[4] = '{MDU_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DL, "div_m7_2"};
    vecs[5] = '{MDU_DIV,   32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DL, "div_by_zero"};
    vecs[6] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DL, "div_min_m1"};
    vecs[7] = '{MDU_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DL, "divu_by_zero"};
    vecs[8] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, DL, "divu_max_16"};

    rst_n       = 1'b0;
    bus.i_srcA  = '0;
    bus.i_srcB  = '0;
    bus.i_mduOp = MDU_NONE;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;

    #12;
    chk("reset hi", bus.or_hi, 32'h0);
    chk("reset lo", bus.or_lo, 32'h0);
    chk("reset busy", 32'(bus.or_busy), 32'd0);
    chk("reset done", 32'(bus.o_done), 32'd0);
    chk("reset result", bus.or_result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].name);
    end

    // Accumulate sequence; move-to ops take effect at the accepting edge with no busy/done.
    issue(MDU_MTHI, 32'd1, 32'd0);
    chk("mthi hi", bus.or_hi, 32'd1);
    chk("mthi busy", 32'(bus.or_busy), 32'd0);
    chk("mthi done", 32'(bus.o_done), 32'd0);
    issue(MDU_MTLO, 32'd2, 32'd0);
    chk("mtlo lo", bus.or_lo, 32'd2);
    chk("mtlo hi", bus.or_hi, 32'd1);
    issue(MDU_MADDU, 32'd3, 32'd4);
    wait_done(ML, 32'd1, 32'hE, "maddu");
    issue(MDU_MSUB, 32'd1, 32'd1);
    wait_done(ML, 32'd1, 32'hD, "msub");

    bus.i_mduOp = MDU_MFHI;
    #1 chk("mfhi result", bus.or_result, 32'd1);
    bus.i_mduOp = MDU_MFLO;
    #1 chk("mflo result", bus.or_result, 32'hD);
    bus.i_mduOp = MDU_NONE;
    #1 chk("none result", bus.or_result, 32'h0);
    @(posedge clk);
    #1;

    // Flush coincident with MTHI in IDLE suppresses the write.
    bus.i_flush = 1'b1;
    issue(MDU_MTHI, 32'h1234, 32'd0);
    bus.i_flush = 1'b0;
    chk("flush_mthi hi", bus.or_hi, 32'd1);

    // A request while busy is dropped; the MULT completes on its own schedule.
    issue(MDU_MULT, 32'd6, 32'd7);
    issue(MDU_MTHI, 32'hDEAD, 32'd0);
    wait_done(ML - 1, 32'd0, 32'h2A, "busy_ignore");

    // DIV flushed on busy cycle 3, then MULT accepted on the very next edge.
    issue(MDU_DIV, 32'd100, 32'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.i_flush = 1'b1;
    @(negedge clk);
    chk("flush_div done_before", 32'(bus.o_done), 32'd0);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("flush_div busy", 32'(bus.or_busy), 32'd0);
    chk("flush_div done", 32'(bus.o_done), 32'd0);
    chk("flush_div hi", bus.or_hi, 32'd0);
    chk("flush_div lo", bus.or_lo, 32'h2A);
    issue(MDU_MULT, 32'd3, 32'hFFFFFFFE);
    chk("after_flush accepted", 32'(bus.or_busy), 32'd1);
    wait_done(ML, 32'hFFFFFFFF, 32'hFFFFFFFA, "after_flush_mult");

    // Flush on the final busy cycle must still block the update.
    issue(MDU_MULT, 32'd7, 32'd7);
    repeat (ML - 1) begin
      @(posedge clk);
      #1;
    end
    chk("final_flush busy_before", 32'(bus.or_busy), 32'd1);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("final_flush busy", 32'(bus.or_busy), 32'd0);
    chk("final_flush done", 32'(bus.o_done), 32'd0);
    chk("final_flush hi", bus.or_hi, 32'hFFFFFFFF);
    chk("final_flush lo", bus.or_lo, 32'hFFFFFFFA);
    @(posedge clk);
    #1;
    chk("final_flush done_late", 32'(bus.o_done), 32'd0);
    chk("final_flush lo_late", bus.or_lo, 32'hFFFFFFFA);

    // Asynchronous reset during MULT busy cycle 2.
    issue(MDU_MULT, 32'd5, 32'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(bus.or_busy), 32'd0);
    chk("midreset hi", bus.or_hi, 32'h0);
    chk("midreset lo", bus.or_lo, 32'h0);
    chk("midreset done", 32'(bus.o_done), 32'd0);
    #1;
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_done) done_seen = 1'b1;
    end
    chk("postreset done_seen", 32'(done_seen), 32'd0);
    chk("postreset hi", bus.or_hi, 32'h0);
    chk("postreset lo", bus.or_lo, 32'h0);
    chk("postreset busy", 32'(bus.or_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
